// File: rtl/lockin_sequencer.sv
// Measurement sequencer for the lock-in chain: reset, arm, settle, capture one phase/quadrature pair.
// Define LOCKIN_SEQ_CONTINUOUS_EN to keep streaming results after each capture until abort.

module lockin_sequencer #(
   parameter int RESET_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] settle_pairs,
   input  logic [CNT_W-1:0] timeout_cycles,
   input  logic             ready_to_calculate,
   input  logic [63:0]      data_out1,
   input  logic             data_out1_valid,
   input  logic [63:0]      data_out2,
   input  logic             data_out2_valid,
   output logic             dp_reset_n,
   output logic             dp_enable,
   output logic [63:0]      result_fase,
   output logic [63:0]      result_cuad,
   output logic             result_valid,
   output logic             busy,
   output logic             done,
   output logic             error_timeout,
   output logic             pair_mismatch,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RST     = 3'd1,
      S_ARM     = 3'd2,
      S_SETTLE  = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6
   } state_t;

   localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

   state_t           cur_state;
   state_t           nxt_state;
   logic [RW-1:0]    rst_cnt;
   logic [CNT_W-1:0] pair_cnt;
   logic [CNT_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] settle_lat;
   logic [CNT_W-1:0] timeout_lat;
   logic [CNT_W-1:0] pair_inc;
   logic [CNT_W-1:0] tmo_inc;
   logic             pair_both;
   logic             pair_one;
   logic             start_ok;
   logic             active;
   logic             tmo_hit;
   logic             capture;

   assign pair_both = data_out1_valid & data_out2_valid;
   assign pair_one  = data_out1_valid ^ data_out2_valid;
   assign start_ok  = start & ~abort & (cur_state inside {S_IDLE, S_DONE, S_ERR});
   assign active    = cur_state inside {S_ARM, S_SETTLE, S_CAPTURE};

   // Counters saturate at all ones rather than wrapping back into range.
   assign pair_inc = (&pair_cnt) ? pair_cnt : pair_cnt + CNT_W'(1);
   assign tmo_inc  = (&tmo_cnt) ? tmo_cnt : tmo_cnt + CNT_W'(1);

   // The budget is measured in cycles spent since ARM entry, so the hit
   // compares the count this cycle completes.
   assign tmo_hit = active & (timeout_lat != '0) & (tmo_inc == timeout_lat);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         cur_state <= S_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
      nxt_state = cur_state;
      capture   = 1'b0;
      case (cur_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_ok) nxt_state = S_RST;
         end
         S_RST: begin
            if (rst_cnt == RST_LAST) nxt_state = S_ARM;
         end
         S_ARM: begin
            if (ready_to_calculate) begin
               nxt_state = (settle_lat == '0) ? S_CAPTURE : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (pair_both && (pair_inc == settle_lat)) nxt_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (pair_both) begin
               capture = 1'b1;
`ifdef LOCKIN_SEQ_CONTINUOUS_EN
               nxt_state = (settle_lat == '0) ? S_CAPTURE : S_SETTLE;
`else
               nxt_state = S_DONE;
`endif
            end
         end
         default: nxt_state = S_IDLE;
      endcase
      if (tmo_hit) begin
         nxt_state = S_ERR;
         capture   = 1'b0;
      end
      if (abort) begin
         nxt_state = S_IDLE;
         capture   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt     <= '0;
         pair_cnt    <= '0;
         tmo_cnt     <= '0;
         settle_lat  <= '0;
         timeout_lat <= '0;
      end else begin
         if ((cur_state == S_RST) && (nxt_state == S_RST)) rst_cnt <= rst_cnt + RW'(1);
         else                                               rst_cnt <= '0;

         if (cur_state == S_SETTLE) begin
            if (pair_both) pair_cnt <= pair_inc;
         end else begin
            pair_cnt <= '0;
         end

         if (!active || capture) tmo_cnt <= '0;
         else                    tmo_cnt <= tmo_inc;

         if (start_ok) begin
            settle_lat  <= settle_pairs;
            timeout_lat <= timeout_cycles;
         end
      end
   end

   // Outputs are registered from the next state so they line up with `state`.
   always_ff @(posedge clk) begin
      if (reset) begin
         dp_reset_n    <= 1'b0;
         dp_enable     <= 1'b0;
         result_fase   <= '0;
         result_cuad   <= '0;
         result_valid  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error_timeout <= 1'b0;
         pair_mismatch <= 1'b0;
      end else begin
         dp_reset_n    <= nxt_state inside {S_ARM, S_SETTLE, S_CAPTURE, S_DONE};
         dp_enable     <= nxt_state inside {S_ARM, S_SETTLE, S_CAPTURE};
         busy          <= nxt_state inside {S_RST, S_ARM, S_SETTLE, S_CAPTURE};
         done          <= (nxt_state == S_DONE);
         error_timeout <= (nxt_state == S_ERR);
         result_valid  <= capture;
         if (capture) begin
            result_fase <= data_out1;
            result_cuad <= data_out2;
         end
         if (start_ok) begin
            pair_mismatch <= 1'b0;
         end else if (!abort && (cur_state inside {S_SETTLE, S_CAPTURE}) && pair_one) begin
            pair_mismatch <= 1'b1;
         end
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_lockin_sequencer.sv
// Self-checking bench for lockin_sequencer: directed test-plan cases plus randomized measurements
// predicted by an event-level model (ready, settle and capture cycles derived from the input schedule).

module tb_lockin_sequencer;

   localparam int RC   = 4;
   localparam int CW   = 32;
   localparam int MAXC = 160;
   localparam int INF  = 1000000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [CW-1:0] settle_pairs;
   logic [CW-1:0] timeout_cycles;
   logic          ready_to_calculate;
   logic [63:0]   data_out1;
   logic          data_out1_valid;
   logic [63:0]   data_out2;
   logic          data_out2_valid;
   logic          dp_reset_n;
   logic          dp_enable;
   logic [63:0]   result_fase;
   logic [63:0]   result_cuad;
   logic          result_valid;
   logic          busy;
   logic          done;
   logic          error_timeout;
   logic          pair_mismatch;
   logic [2:0]    state;

   lockin_sequencer #(.RESET_CYCLES(RC), .CNT_W(CW)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .abort              (abort),
      .settle_pairs       (settle_pairs),
      .timeout_cycles     (timeout_cycles),
      .ready_to_calculate (ready_to_calculate),
      .data_out1          (data_out1),
      .data_out1_valid    (data_out1_valid),
      .data_out2          (data_out2),
      .data_out2_valid    (data_out2_valid),
      .dp_reset_n         (dp_reset_n),
      .dp_enable          (dp_enable),
      .result_fase        (result_fase),
      .result_cuad        (result_cuad),
      .result_valid       (result_valid),
      .busy               (busy),
      .done               (done),
      .error_timeout      (error_timeout),
      .pair_mismatch      (pair_mismatch),
      .state              (state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-cycle input schedule for one measurement; cycle 0 carries the start pulse.
   logic        st_a [MAXC];
   logic        ab_a [MAXC];
   logic        rdy_a[MAXC];
   logic        v1_a [MAXC];
   logic        v2_a [MAXC];
   logic [63:0] d1_a [MAXC];
   logic [63:0] d2_a [MAXC];
   int          sc_settle;
   int          sc_tmo;
   int          abort_at;
   logic [63:0] exp_fase = '0;
   logic [63:0] exp_cuad = '0;

   function automatic logic [9:0] obs_vec();
      return {state, dp_reset_n, dp_enable, busy, done, error_timeout, result_valid, pair_mismatch};
   endfunction

   // Output table of the state codes.
   function automatic logic [9:0] exp_vec(input int code, input bit rv, input bit mm);
      logic rn, en, bz, dn, er;
      rn = (code >= 2) && (code <= 5);
      en = (code >= 2) && (code <= 4);
      bz = (code >= 1) && (code <= 4);
      dn = (code == 5);
      er = (code == 6);
      return {3'(code), rn, en, bz, dn, er, rv, mm};
   endfunction

   task automatic clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         st_a[c] = 1'b0; ab_a[c] = 1'b0; rdy_a[c] = 1'b0;
         v1_a[c] = 1'b0; v2_a[c] = 1'b0; d1_a[c] = '0; d2_a[c] = '0;
      end
      sc_settle = 0;
      sc_tmo    = 0;
      abort_at  = -1;
   endtask

   task automatic drive_zero();
      start = 1'b0; abort = 1'b0; ready_to_calculate = 1'b0;
      data_out1_valid = 1'b0; data_out2_valid = 1'b0;
      data_out1 = '0; data_out2 = '0; settle_pairs = '0; timeout_cycles = '0;
   endtask

   task automatic run_scn(input string name);
      int a, r, q, p, d, k, e, fin, cnt, mm_first, hi, code;
      bit rv;
      a = RC + 1;
      d = (sc_tmo == 0) ? INF : a + sc_tmo - 1;
      r = INF;
      for (int c = a; c < MAXC; c++) if (rdy_a[c]) begin r = c; break; end
      q = INF;
      p = INF;
      cnt = 0;
      if (r < INF) begin
         if (sc_settle == 0) q = r;
         for (int c = r + 1; c < MAXC; c++) begin
            if (v1_a[c] && v2_a[c]) begin
               if (cnt == sc_settle) begin p = c; break; end
               cnt++;
               if (cnt == sc_settle) q = c;
            end
         end
      end
      k = (abort_at < 1) ? INF : abort_at;
      if (k <= p && k <= d) begin
         fin = 0; e = k;
      end else begin
         if (abort_at >= 0 && abort_at < MAXC) ab_a[abort_at] = 1'b0;
         if (d <= p) begin fin = 6; e = d; end
         else        begin fin = 5; e = p; end
      end
      if (e > MAXC - 4) begin
         $display("FAIL %s: schedule does not finish inside the stimulus window", name);
         $fatal(1);
      end
      st_a[0] = 1'b1;
      for (int c = 1; c <= e; c++) st_a[c] = st_a[c] | ($urandom_range(0, 9) == 0);
      for (int c = e + 1; c < MAXC; c++) st_a[c] = 1'b0;
      mm_first = INF;
      hi = (fin == 0) ? k - 1 : e;
      if (r < INF) begin
         for (int c = r + 1; c <= hi; c++) begin
            if ((v1_a[c] ^ v2_a[c]) && mm_first == INF) mm_first = c;
         end
      end

      for (int c = 0; c <= e + 2; c++) begin
         start              = st_a[c];
         abort              = ab_a[c];
         settle_pairs       = (c == 0) ? CW'(sc_settle) : CW'($urandom);
         timeout_cycles     = (c == 0) ? CW'(sc_tmo) : CW'($urandom);
         ready_to_calculate = rdy_a[c];
         data_out1_valid    = v1_a[c];
         data_out2_valid    = v2_a[c];
         data_out1          = d1_a[c];
         data_out2          = d2_a[c];
         @(posedge clk);
         #1;
         if (c + 1 > e)      code = fin;
         else if (c + 1 <= RC) code = 1;
         else if (c + 1 <= r)  code = 2;
         else if (c + 1 <= q)  code = 3;
         else                  code = 4;
         rv = (fin == 5) && (c + 1 == e + 1);
         check($sformatf("%s cyc%0d", name, c + 1), {54'd0, obs_vec()},
               {54'd0, exp_vec(code, rv, (c + 1) > mm_first)});
      end
      if (fin == 5) begin
         exp_fase = d1_a[p];
         exp_cuad = d2_a[p];
      end
      check({name, " fase"}, result_fase, exp_fase);
      check({name, " cuad"}, result_cuad, exp_cuad);
      drive_zero();
   endtask

   task automatic gen_random();
      bit never;
      int ra, x;
      clear_stim();
      sc_settle = $urandom_range(0, 4);
      sc_tmo    = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(8, 40);
      never     = (sc_tmo != 0) && ($urandom_range(0, 4) == 0);
      ra        = RC + 1 + $urandom_range(0, 8);
      for (int c = 0; c < MAXC; c++) begin
         rdy_a[c] = (c < RC + 1) ? 1'($urandom_range(0, 1)) : (!never && c >= ra);
         x = $urandom_range(0, 9);
         v1_a[c] = (c >= 60) || x < 6;
         v2_a[c] = (c >= 60) || x < 5 || x == 6;
         d1_a[c] = {$urandom, $urandom};
         d2_a[c] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 3) == 0) begin
         abort_at = $urandom_range(1, 30);
         ab_a[abort_at] = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b1;
      drive_zero();
      repeat (2) @(posedge clk);
      #1;
      check("reset vec", {54'd0, obs_vec()}, 64'd0);
      check("reset fase", result_fase, 64'd0);
      check("reset cuad", result_cuad, 64'd0);
      reset = 1'b0;

`ifdef LOCKIN_SEQ_CONTINUOUS_EN
      begin
         logic [63:0] got_q[$];
         int pulses;
         pulses = 0;
         for (int c = 0; c < 20; c++) begin
            start              = (c == 0);
            settle_pairs       = (c == 0) ? CW'(1) : CW'($urandom);
            timeout_cycles     = '0;
            ready_to_calculate = (c >= 6);
            data_out1_valid    = (c >= 8 && c <= 13);
            data_out2_valid    = (c >= 8 && c <= 13);
            data_out1          = 64'(c - 7);
            data_out2          = 64'(c);
            @(posedge clk);
            #1;
            if (result_valid) begin
               pulses++;
               got_q.push_back(result_fase);
            end
            check($sformatf("cont done cyc%0d", c + 1), {63'd0, done}, 64'd0);
            check($sformatf("cont busy cyc%0d", c + 1), {63'd0, busy}, 64'd1);
         end
         check("cont pulses", 64'(pulses), 64'd3);
         for (int i = 0; i < 3; i++) begin
            check($sformatf("cont fase%0d", i), (i < got_q.size()) ? got_q[i] : 64'hDEAD,
                  64'(2 * (i + 1)));
         end
         drive_zero();
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
         check("cont abort state", {61'd0, state}, 64'd0);
         check("cont abort busy", {63'd0, busy}, 64'd0);
      end
`else
      // Single pair, no settling.
      clear_stim();
      for (int c = 8; c < MAXC; c++) rdy_a[c] = 1'b1;
      v1_a[10] = 1'b1; v2_a[10] = 1'b1;
      d1_a[10] = 64'h10; d2_a[10] = 64'hFFFF_FFFF_FFFF_FFFB;
      run_scn("tp_single");
      check("tp_single fase const", result_fase, 64'h10);
      check("tp_single cuad const", result_cuad, 64'hFFFF_FFFF_FFFF_FFFB);

      // Three settling pairs discarded, the fourth captured.
      clear_stim();
      sc_settle = 3;
      for (int c = 8; c < MAXC; c++) rdy_a[c] = 1'b1;
      for (int c = 10; c <= 14; c++) begin
         v1_a[c] = 1'b1; v2_a[c] = 1'b1; d1_a[c] = 64'(c - 9); d2_a[c] = 64'(c);
      end
      run_scn("tp_settle");
      check("tp_settle fase const", result_fase, 64'd4);

      // Ready never arrives: timeout, results held.
      clear_stim();
      sc_tmo = 20;
      for (int c = 12; c < 30; c += 3) begin v1_a[c] = 1'b1; v2_a[c] = 1'b1; d1_a[c] = 64'hBAD; end
      run_scn("tp_timeout");
      check("tp_timeout fase held", result_fase, 64'd4);

      // Abort in SETTLE with start pulses while busy.
      clear_stim();
      sc_settle = 4;
      for (int c = 6; c < MAXC; c++) rdy_a[c] = 1'b1;
      for (int c = 8; c <= 12; c += 2) begin v1_a[c] = 1'b1; v2_a[c] = 1'b1; end
      st_a[9] = 1'b1; st_a[10] = 1'b1;
      abort_at = 11; ab_a[11] = 1'b1;
      run_scn("tp_abort");

      // Single-sided valid in SETTLE sets pair_mismatch without counting.
      clear_stim();
      sc_settle = 2;
      for (int c = 6; c < MAXC; c++) rdy_a[c] = 1'b1;
      v1_a[8] = 1'b1; d1_a[8] = 64'hEE;
      for (int c = 10; c <= 13; c++) begin
         v1_a[c] = (c != 11); v2_a[c] = (c != 11); d1_a[c] = 64'(c + 100); d2_a[c] = 64'(c);
      end
      run_scn("tp_mismatch");
      check("tp_mismatch fase const", result_fase, 64'd113);
      check("tp_mismatch flag", {63'd0, pair_mismatch}, 64'd1);

      // Start together with abort is ignored; abort leaves DONE, flag held.
      start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1;
      drive_zero();
      check("start_abort state", {61'd0, state}, 64'd0);
      check("start_abort busy", {63'd0, busy}, 64'd0);
      check("start_abort done", {63'd0, done}, 64'd0);
      check("start_abort mm held", {63'd0, pair_mismatch}, 64'd1);
      check("start_abort fase held", result_fase, 64'd113);

      // Synchronous reset in the middle of a measurement.
      start = 1'b1; settle_pairs = CW'(2); ready_to_calculate = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive_zero();
      check("midreset vec", {54'd0, obs_vec()}, 64'd0);
      check("midreset fase", result_fase, 64'd0);
      exp_fase = '0;
      exp_cuad = '0;

      for (int i = 0; i < 40; i++) begin
         gen_random();
         run_scn($sformatf("rnd%0d", i));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lockin_sequencer.md
Name: lockin_sequencer

Overview:
- Measurement sequencer for the lock-in chain: coherent averager, reference mixer and two moving-average filters.
- Runs one measurement per `start`:
  - holds the chain in reset so it latches its parameters;
  - enables the chain;
  - waits for the filters to report ready;
  - discards a programmable number of settling output pairs;
  - captures one phase/quadrature result pair.
- Sits between the host control registers and the processing top: it drives the chain's `reset_n`/`enable_gral` and consumes its `data_out1`/`data_out2` streams.

Parameters:
- RESET_CYCLES, 4, cycles the chain's active-low reset is held (minimum 1).
- CNT_W, 32, width of the settle and timeout counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a measurement; accepted only in IDLE, DONE or ERR
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- settle_pairs  in  CNT_W  valid output pairs to discard before capture; sampled on accepted start
- timeout_cycles  in  CNT_W  cycle budget from ARM entry to capture; 0 = no timeout; sampled on accepted start
- ready_to_calculate  in  1  from chain: both filters are ready
- data_out1  in  64  from chain: phase result (signed)
- data_out1_valid  in  1  phase result valid
- data_out2  in  64  from chain: quadrature result (signed)
- data_out2_valid  in  1  quadrature result valid
- dp_reset_n  out  1  to chain `reset_n`; active-low
- dp_enable  out  1  to chain `enable_gral`
- result_fase  out  64  captured phase
- result_cuad  out  64  captured quadrature
- result_valid  out  1  one-cycle pulse when results update
- busy  out  1  high in RST, ARM, SETTLE, CAPTURE
- done  out  1  level; high in DONE
- error_timeout  out  1  level; high in ERR
- pair_mismatch  out  1  sticky; set when exactly one of the two valids is high in SETTLE/CAPTURE; cleared on accepted start
- state  out  3  current state code, for debug

Behaviour:
- All outputs are registered. Reset values:
  - state = IDLE (0)
  - dp_reset_n = 0, dp_enable = 0
  - result_fase = 0, result_cuad = 0
  - result_valid = 0, busy = 0, done = 0, error_timeout = 0, pair_mismatch = 0
- State codes and outputs:

| State | Code | dp_reset_n | dp_enable |
|---|---|---|---|
| IDLE | 0 | 0 | 0 |
| RST | 1 | 0 | 0 |
| ARM | 2 | 1 | 1 |
| SETTLE | 3 | 1 | 1 |
| CAPTURE | 4 | 1 | 1 |
| DONE | 5 | 1 | 0 |
| ERR | 6 | 0 | 0 |

- IDLE/DONE/ERR on start:
  - latch settle_pairs and timeout_cycles;
  - clear done, error_timeout and pair_mismatch;
  - go to RST, with the reset counter = 0.
- RST:
  - counter increments each cycle;
  - after RESET_CYCLES cycles in RST, go to ARM.
  - If start is accepted at cycle 0, dp_reset_n is low through cycle RESET_CYCLES and dp_enable rises at cycle RESET_CYCLES+1.
- ARM: wait for ready_to_calculate = 1.
  - If the latched settle_pairs = 0, go to CAPTURE; otherwise go to SETTLE.
  - The timeout counter is cleared on ARM entry and increments every cycle in ARM, SETTLE and CAPTURE.
- SETTLE:
  - each cycle with data_out1_valid && data_out2_valid increments the pair counter;
  - when the counter reaches settle_pairs, go to CAPTURE. The pair that reaches the count is discarded, not captured.
- CAPTURE:
  - on the first coincident valid pair, latch data_out1 → result_fase and data_out2 → result_cuad;
  - pulse result_valid for 1 cycle, coincident with the new result values;
  - go to DONE.
- Timeout: if the latched timeout_cycles ≠ 0 and the timeout counter equals timeout_cycles in ARM, SETTLE or CAPTURE, go to ERR.
  - Results are not updated.
  - Counter arithmetic is unsigned CNT_W-bit and saturates at all ones (no wrap).
- Priority within one cycle: reset > abort > timeout > capture/transition.
  - A capture pair arriving in the same cycle as the timeout hit is dropped; the block goes to ERR.
- abort:
  - from any state, go to IDLE next cycle;
  - busy drops; done and error_timeout clear;
  - results and pair_mismatch are held.
- start while busy is ignored, as is start in the same cycle as abort.
- Valid inputs outside SETTLE/CAPTURE are ignored.
- A single-sided valid never advances the counters; it only sets pair_mismatch.
- reset asserted mid-operation returns all state and outputs to their reset values on the next edge.

Optional Feature:
- Macro: LOCKIN_SEQ_CONTINUOUS_EN.
- Defined: after each capture, go back to SETTLE with the pair counter = 0 and the timeout counter = 0, instead of going to DONE.
  - Results stream every settle_pairs+1 coincident pairs until abort.
  - done is never asserted; busy stays high.
- Undefined: single-shot behaviour as above.

Test Plan:
- RESET_CYCLES=4, settle_pairs=0, timeout=0, start at cycle 0, ready at cycle 8, one pair (fase=0x10, cuad=-5) at cycle 10:
  - dp_reset_n low cycles 1–4, dp_enable high from cycle 5;
  - result_valid pulses with result_fase=0x10, result_cuad=-5;
  - done=1 on the following cycle.
- settle_pairs=3, five coincident pairs with fase = 1,2,3,4,5 → result_fase=4; the three earlier pairs are discarded.
- timeout_cycles=20, ready never asserted → error_timeout=1 exactly 20 cycles after ARM entry; dp_reset_n=0; results unchanged.
- Mid-SETTLE: assert abort; also assert start while busy:
  - abort → IDLE next cycle, busy=0, done=0;
  - start while busy → no effect on state.
- Only data_out1_valid pulsed during SETTLE → pair_mismatch=1, pair counter unchanged; next accepted start clears pair_mismatch.
- With LOCKIN_SEQ_CONTINUOUS_EN, settle_pairs=1, 6 coincident pairs → 3 result_valid pulses (on pairs 2, 4, 6), done stays 0.
